cache_set: RTL and testbench

One line of the direct-mapped data cache: a 5-bit tag, a valid bit, a dirty bit and four 16-bit words. The cache top level instantiates one `cache_set` per index and drives only the enabled set. The block performs tag comparison and word-granular reads and writes. Lookups are combinational; all state updates happen on the clock edge.

---
 rtl/cache_set_pkg.sv | 17 +
 rtl/cache_set_if.sv | 31 +++
 rtl/set_data_bank.sv | 33 +++
 rtl/cache_set.sv | 77 +++++++
 tb/tb_cache_set.sv | 127 ++++++++++++
 5 files changed

// File: rtl/cache_set_pkg.sv
// Shared definitions for one line of the direct-mapped data cache.
package cache_set_pkg;

  localparam int unsigned TAG_W  = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned WORD_W = $clog2(WORDS);

  // Full architectural view of one cache line.
  typedef struct packed {
    logic [TAG_W-1:0]             tag;
    logic                         valid;
    logic                         dirty;
    logic [WORDS-1:0][DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_set_if.sv
// Access bus between the cache top level (master) and one cache_set (slave).
interface cache_set_if #(
  parameter int unsigned TAG_W  = cache_set_pkg::TAG_W,
  parameter int unsigned DATA_W = cache_set_pkg::DATA_W,
  parameter int unsigned WORD_W = cache_set_pkg::WORD_W
);

  logic              en;
  logic [WORD_W-1:0] word;
  logic              cmp;
  logic              wr;
  logic [TAG_W-1:0]  tag_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              hit;
  logic              dirty_out;
  logic [TAG_W-1:0]  tag_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;

  modport master (
    output en, word, cmp, wr, tag_in, data_in, valid_in,
    input  hit, dirty_out, tag_out, data_out, valid_out
  );

  modport slave (
    input  en, word, cmp, wr, tag_in, data_in, valid_in,
    output hit, dirty_out, tag_out, data_out, valid_out
  );

endinterface

// File: rtl/set_data_bank.sv
// Word storage for one cache line: one synchronous write port, one combinational read port.
module set_data_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned IDX_W  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [WORDS];

  // Clear every word on reset; otherwise update only the addressed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read shows the pre-edge contents of the addressed word.
  always_comb begin
    rdata = mem_q[addr];
  end

endmodule

// File: rtl/cache_set.sv
// One direct-mapped cache line: tag compare plus word-granular read/write.
module cache_set
  import cache_set_pkg::*;
#(
  parameter int unsigned TAG_W  = cache_set_pkg::TAG_W,
  parameter int unsigned DATA_W = cache_set_pkg::DATA_W,
  parameter int unsigned WORDS  = cache_set_pkg::WORDS,
  parameter int unsigned WORD_W = $clog2(WORDS)
) (
  input logic         clk,
  input logic         rst,
  cache_set_if.slave  bus
);

  logic [TAG_W-1:0]  tag_q;
  logic              valid_q;
  logic              dirty_q;
  logic [DATA_W-1:0] rdata;

  logic match;
  logic cmp_wr_hit;
  logic dir_wr;
  logic data_we;

  // Access decode; an invalid line never matches, whatever its stored tag.
  always_comb begin
    match      = valid_q && (tag_q == bus.tag_in);
    cmp_wr_hit = bus.en && bus.wr && bus.cmp && match;
    dir_wr     = bus.en && bus.wr && !bus.cmp;
    data_we    = cmp_wr_hit || dir_wr;
  end

  set_data_bank #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .IDX_W  (WORD_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (data_we),
    .addr  (bus.word),
    .wdata (bus.data_in),
    .rdata (rdata)
  );

  // Line metadata: fills install tag/valid and clean the line, write hits dirty it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
    end else if (dir_wr) begin
      tag_q   <= bus.tag_in;
      valid_q <= bus.valid_in;
      dirty_q <= 1'b0;
    end else if (cmp_wr_hit) begin
      dirty_q <= 1'b1;
    end
  end

  // Outputs reflect pre-edge state and idle at zero when the set is not selected.
  always_comb begin
    bus.hit       = 1'b0;
    bus.dirty_out = 1'b0;
    bus.tag_out   = '0;
    bus.data_out  = '0;
    bus.valid_out = 1'b0;
    if (bus.en) begin
      bus.hit       = bus.cmp && match;
      bus.dirty_out = dirty_q;
      bus.tag_out   = tag_q;
      bus.data_out  = rdata;
      bus.valid_out = valid_q;
    end
  end

endmodule

// File: tb/tb_cache_set.sv
// Directed self-checking bench for cache_set with an expected-output scoreboard.
module tb_cache_set;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cache_set_if bus ();

  cache_set dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        hit;
    logic        dirty;
    logic [4:0]  tag;
    logic [15:0] data;
    logic        valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_field(input string name, input string field,
                             input logic [15:0] obs, input logic [15:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %h expected %h", name, field, obs, exp_v);
    end
  endtask

  // Pop the oldest expectation and compare against the settled outputs.
  task automatic check_outputs();
    exp_t e;
    n_tests++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    check_field(e.name, "hit",   {15'd0, bus.hit},       {15'd0, e.hit});
    check_field(e.name, "dirty", {15'd0, bus.dirty_out}, {15'd0, e.dirty});
    check_field(e.name, "tag",   {11'd0, bus.tag_out},   {11'd0, e.tag});
    check_field(e.name, "data",  bus.data_out,           e.data);
    check_field(e.name, "valid", {15'd0, bus.valid_out}, {15'd0, e.valid});
  endtask

  // Drive one access away from the rising edge, queue its expected outputs, then check them.
  task automatic step(input string name, input logic r, input logic en, input logic [1:0] word,
                      input logic cmp, input logic wr, input logic [4:0] tag,
                      input logic [15:0] data, input logic vin,
                      input logic e_hit, input logic e_dirty, input logic [4:0] e_tag,
                      input logic [15:0] e_data, input logic e_valid);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.en       = en;
    bus.word     = word;
    bus.cmp      = cmp;
    bus.wr       = wr;
    bus.tag_in   = tag;
    bus.data_in  = data;
    bus.valid_in = vin;
    e.name  = name;
    e.hit   = e_hit;
    e.dirty = e_dirty;
    e.tag   = e_tag;
    e.data  = e_data;
    e.valid = e_valid;
    sb_q.push_back(e);
    #2;
    check_outputs();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    bus.en = 1'b0; bus.word = '0; bus.cmp = 1'b0; bus.wr = 1'b0;
    bus.tag_in = '0; bus.data_in = '0; bus.valid_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    //    name          rst en  w  cmp wr  tag    data      vin  hit dty tag    data      vld
    step("reset_rd",    0, 1, 0, 1, 0, 5'h00, 16'h0000, 0,   0, 0, 5'h00, 16'h0000, 0);
    step("fill_w2",     0, 1, 2, 0, 1, 5'h0A, 16'hBEEF, 1,   0, 0, 5'h00, 16'h0000, 0);
    step("cmp_rd_w2",   0, 1, 2, 1, 0, 5'h0A, 16'h0000, 0,   1, 0, 5'h0A, 16'hBEEF, 1);
    step("cmp_wr_w1",   0, 1, 1, 1, 1, 5'h0A, 16'h1234, 0,   1, 0, 5'h0A, 16'h0000, 1);
    step("rd_w1_dirty", 0, 1, 1, 1, 0, 5'h0A, 16'h0000, 0,   1, 1, 5'h0A, 16'h1234, 1);
    step("rd_w2_kept",  0, 1, 2, 1, 0, 5'h0A, 16'h0000, 0,   1, 1, 5'h0A, 16'hBEEF, 1);
    step("cmp_wr_miss", 0, 1, 1, 1, 1, 5'h0B, 16'h5555, 0,   0, 1, 5'h0A, 16'h1234, 1);
    step("dir_rd_w1",   0, 1, 1, 0, 0, 5'h00, 16'h0000, 0,   0, 1, 5'h0A, 16'h1234, 1);
    step("cmp_wr_w0",   0, 1, 0, 1, 1, 5'h0A, 16'h0C0C, 0,   1, 1, 5'h0A, 16'h0000, 1);
    step("disabled_wr", 0, 0, 0, 0, 1, 5'h0A, 16'hFFFF, 1,   0, 0, 5'h00, 16'h0000, 0);
    step("reen_rd_w0",  0, 1, 0, 0, 0, 5'h00, 16'h0000, 0,   0, 1, 5'h0A, 16'h0C0C, 1);
    step("cmp_rd_miss", 0, 1, 0, 1, 0, 5'h0B, 16'h0000, 0,   0, 1, 5'h0A, 16'h0C0C, 1);
    // Fill with valid_in=0 and tag 0: the line must never hit afterwards.
    step("fill_inval",  0, 1, 3, 0, 1, 5'h00, 16'h7777, 0,   0, 1, 5'h0A, 16'h0000, 1);
    step("inval_wr",    0, 1, 3, 1, 1, 5'h00, 16'h1111, 0,   0, 0, 5'h00, 16'h7777, 0);
    step("inval_rd_w3", 0, 1, 3, 0, 0, 5'h00, 16'h0000, 0,   0, 0, 5'h00, 16'h7777, 0);
    // Reset wins over a direct write in the same cycle.
    step("rst_fill",    1, 1, 1, 0, 1, 5'h1F, 16'hAAAA, 1,   0, 0, 5'h00, 16'h1234, 0);
    step("post_rst_w1", 0, 1, 1, 0, 0, 5'h00, 16'h0000, 0,   0, 0, 5'h00, 16'h0000, 0);
    step("post_rst_w2", 0, 1, 2, 1, 0, 5'h00, 16'h0000, 0,   0, 0, 5'h00, 16'h0000, 0);

    n_tests++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
